// File: rtl/up_packet_link.sv
// up_packet_link: uP byte-handshake link that turns a command packet into one register access and returns the reply
module up_packet_link #(
    parameter int NOS_READ_BYTES  = 6,
    parameter int NOS_WRITE_BYTES = 8,
    parameter int EXEC_TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        async_uP_start,
    input  logic        async_uP_handshake_1,
    input  logic        async_uP_RW,
    input  logic [7:0]  uP_data_in,
    output logic [7:0]  uP_data_out,
    output logic        uP_data_oe,
    output logic        uP_handshake_2,
    output logic        uP_ack,
    output logic        reg_req,
    output logic [7:0]  reg_cmd,
    output logic [7:0]  reg_address,
    output logic [31:0] reg_wr_data,
    input  logic        reg_done,
    input  logic [31:0] reg_rd_data,
    input  logic [31:0] reg_status
);
    typedef enum logic [2:0] {
        IDLE, RX_WAIT_H1, RX_WAIT_H1_LOW, EXEC, TX_PRESENT, TX_WAIT_H1, TX_WAIT_H1_LOW, ACK
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  start_sync_q, h1_sync_q, rw_sync_q;
    logic        start_prev_q;
    logic        s_start, s_h1, s_rw, start_edge;
    logic [7:0]  count_q, count_d;
    logic [7:0]  cmd_q [NOS_READ_BYTES];
    logic [7:0]  cmd_d [NOS_READ_BYTES];
    logic [63:0] reply_q, reply_d;
    logic [31:0] tmo_q, tmo_d;
    logic [7:0]  data_out_q, data_out_d;
    logic        hs2_q, hs2_d, ack_q, ack_d, req_q, req_d;

    assign s_start        = start_sync_q[1];
    assign s_h1           = h1_sync_q[1];
    assign s_rw           = rw_sync_q[1];
    assign start_edge     = s_start & ~start_prev_q;
    assign uP_data_out    = data_out_q;
    assign uP_handshake_2 = hs2_q;
    assign uP_ack         = ack_q;
    assign reg_req        = req_q;
    assign reg_cmd        = cmd_q[0];
    assign reg_address    = cmd_q[1];
    assign reg_wr_data    = {cmd_q[5], cmd_q[4], cmd_q[3], cmd_q[2]};
    // the pad is driven only while the reply is in flight and the uP has released the bus
    assign uP_data_oe     = (state_q == TX_PRESENT || state_q == TX_WAIT_H1 || state_q == TX_WAIT_H1_LOW) && !s_rw;

    // synchronizers plus all protocol state
    always_ff @(posedge clk) begin
        if (reset) begin
            start_sync_q <= '0;
            h1_sync_q    <= '0;
            rw_sync_q    <= '0;
            start_prev_q <= 1'b0;
            state_q      <= IDLE;
            count_q      <= '0;
            cmd_q        <= '{default: 8'h00};
            reply_q      <= '0;
            tmo_q        <= '0;
            data_out_q   <= '0;
            hs2_q        <= 1'b0;
            ack_q        <= 1'b0;
            req_q        <= 1'b0;
        end else begin
            start_sync_q <= {start_sync_q[0], async_uP_start};
            h1_sync_q    <= {h1_sync_q[0], async_uP_handshake_1};
            rw_sync_q    <= {rw_sync_q[0], async_uP_RW};
            start_prev_q <= s_start;
            state_q      <= state_d;
            count_q      <= count_d;
            cmd_q        <= cmd_d;
            reply_q      <= reply_d;
            tmo_q        <= tmo_d;
            data_out_q   <= data_out_d;
            hs2_q        <= hs2_d;
            ack_q        <= ack_d;
            req_q        <= req_d;
        end
    end

    // next state: a start edge restarts from any state, otherwise walk the receive/execute/reply sequence
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        cmd_d      = cmd_q;
        reply_d    = reply_q;
        tmo_d      = tmo_q;
        data_out_d = data_out_q;
        hs2_d      = hs2_q;
        ack_d      = ack_q;
        req_d      = 1'b0;
        if (start_edge) begin
            state_d = RX_WAIT_H1;
            count_d = '0;
            ack_d   = 1'b0;
            hs2_d   = 1'b0;
        end else begin
            case (state_q)
                RX_WAIT_H1: if (s_h1 && s_rw) begin
                    for (int i = 0; i < NOS_READ_BYTES; i++) if (int'(count_q) == i) cmd_d[i] = uP_data_in;
                    hs2_d   = 1'b1;
                    state_d = RX_WAIT_H1_LOW;
                end
                RX_WAIT_H1_LOW: if (!s_h1) begin
                    hs2_d   = 1'b0;
                    count_d = (count_q == 8'(NOS_READ_BYTES - 1)) ? 8'd0 : count_q + 8'd1;
                    state_d = (count_q == 8'(NOS_READ_BYTES - 1)) ? EXEC : RX_WAIT_H1;
                    req_d   = (count_q == 8'(NOS_READ_BYTES - 1));
                    tmo_d   = '0;
                end
                EXEC: begin
                    tmo_d = tmo_q + 32'd1;
                    if (reg_done) begin
                        reply_d = {reg_status, reg_rd_data};
                        state_d = TX_PRESENT;
                    end else if (tmo_q == 32'(EXEC_TIMEOUT - 1)) begin
                        reply_d = {32'hFFFF_FFFF, 32'h0};
                        state_d = TX_PRESENT;
                    end
                    if (state_d == TX_PRESENT) data_out_d = reply_d[7:0];
                end
                TX_PRESENT: begin
                    hs2_d   = 1'b1;
                    state_d = TX_WAIT_H1;
                end
                TX_WAIT_H1: if (s_h1) begin
                    hs2_d   = 1'b0;
                    state_d = TX_WAIT_H1_LOW;
                end
                TX_WAIT_H1_LOW: if (!s_h1) begin
                    count_d = count_q + 8'd1;
                    if (count_q == 8'(NOS_WRITE_BYTES - 1)) begin
                        state_d = ACK;
                        ack_d   = 1'b1;
                    end else begin
                        state_d = TX_PRESENT;
                        for (int i = 0; i < 8; i++) if (int'(count_d) == i) data_out_d = reply_q[8*i +: 8];
                    end
                end
                ACK: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_up_packet_link.sv
// tb_up_packet_link: table, random and corner-case checks of the uP packet link against a packet-level model
module tb_up_packet_link;
    localparam int TMO = 255;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        async_uP_start = 1'b0;
    logic        async_uP_handshake_1 = 1'b0;
    logic        async_uP_RW = 1'b1;
    logic [7:0]  uP_data_in = 8'h00;
    logic [7:0]  uP_data_out;
    logic        uP_data_oe, uP_handshake_2, uP_ack, reg_req;
    logic [7:0]  reg_cmd, reg_address;
    logic [31:0] reg_wr_data;
    logic        reg_done = 1'b0;
    logic [31:0] reg_rd_data = '0, reg_status = '0;

    int          vectors = 0, miscompares = 0;
    int          n_req = 0, max_lat = 0;
    logic [7:0]  seen_cmd, seen_addr;
    logic [31:0] seen_wr;
    int          rsp_delay = 0;
    logic [31:0] rsp_data = '0, rsp_status = '0;

    typedef struct {
        logic [47:0] pkt;
        int          delay;
        logic [31:0] rd;
        logic [31:0] st;
        logic [7:0]  exp_cmd;
        logic [7:0]  exp_addr;
        logic [31:0] exp_wr;
        logic [63:0] exp_reply;
    } vec_t;
    vec_t tbl [5];

    up_packet_link #(.NOS_READ_BYTES(6), .NOS_WRITE_BYTES(8), .EXEC_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .async_uP_start(async_uP_start), .async_uP_handshake_1(async_uP_handshake_1), .async_uP_RW(async_uP_RW),
        .uP_data_in(uP_data_in), .uP_data_out(uP_data_out), .uP_data_oe(uP_data_oe),
        .uP_handshake_2(uP_handshake_2), .uP_ack(uP_ack),
        .reg_req(reg_req), .reg_cmd(reg_cmd), .reg_address(reg_address), .reg_wr_data(reg_wr_data),
        .reg_done(reg_done), .reg_rd_data(reg_rd_data), .reg_status(reg_status)
    );

    always #10 clk = ~clk;

    // count every request cycle and capture the fields it carried
    always @(negedge clk) if (reg_req === 1'b1) begin
        n_req++;
        seen_cmd  = reg_cmd;
        seen_addr = reg_address;
        seen_wr   = reg_wr_data;
    end

    // register responder: reg_done rsp_delay cycles after the request (0 = same cycle, <0 = never)
    always begin
        @(negedge clk);
        if (reg_req === 1'b1 && rsp_delay >= 0) begin
            repeat (rsp_delay) @(negedge clk);
            reg_rd_data = rsp_data;
            reg_status  = rsp_status;
            reg_done    = 1'b1;
            @(negedge clk);
            reg_done    = 1'b0;
        end
    end

    initial begin
        #(20 * 95000);
        $display("FAIL watchdog: simulation did not finish within 95000 cycles");
        $fatal(1);
    end

    // reference: a reply is the 64-bit {status, data} word sent LSB first; a timeout substitutes 0 / all-ones
    function automatic logic [63:0] model_reply(input int delay, input logic [31:0] rd, input logic [31:0] st);
        return (delay < 0 || delay >= TMO) ? {32'hFFFF_FFFF, 32'h0} : {st, rd};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_hs2(input logic v, input int budget, output int n);
        n = 0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (uP_handshake_2 === v) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic start_pulse();
        async_uP_start = 1'b1;
        repeat (4) @(negedge clk);
        async_uP_start = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, output bit ok);
        int n1, n2;
        async_uP_RW = 1'b1;
        uP_data_in = b;
        async_uP_handshake_1 = 1'b1;
        wait_hs2(1'b1, 8, n1);
        if (n1 > max_lat) max_lat = n1;
        async_uP_handshake_1 = 1'b0;
        wait_hs2(1'b0, 8, n2);
        ok = (n1 != 0) && (n2 != 0);
    endtask

    task automatic recv_byte(input int budget, output logic [7:0] b, output logic oe, output bit ok);
        int n1, n2;
        async_uP_RW = 1'b0;
        wait_hs2(1'b1, budget, n1);
        b  = uP_data_out;
        oe = uP_data_oe;
        async_uP_handshake_1 = 1'b1;
        wait_hs2(1'b0, 8, n2);
        async_uP_handshake_1 = 1'b0;
        ok = (n1 != 0) && (n2 != 0);
    endtask

    task automatic run_txn(input logic [47:0] pkt, input int delay, input logic [31:0] rd, input logic [31:0] st,
                           output logic [63:0] got, output logic oe_all, output bit ok, output logic ack);
        bit k;
        logic [7:0] b;
        logic oe;
        rsp_delay = delay; rsp_data = rd; rsp_status = st;
        ok = 1'b1; oe_all = 1'b1; got = '0; ack = 1'b0;
        start_pulse();
        for (int i = 0; i < 6; i++) begin
            send_byte(pkt[8*i +: 8], k);
            ok &= k;
        end
        for (int i = 0; i < 8; i++) begin
            recv_byte(i == 0 ? 300 : 12, b, oe, k);
            got[8*i +: 8] = b;
            oe_all &= oe;
            ok &= k;
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (uP_ack === 1'b1) begin
                ack = 1'b1;
                break;
            end
        end
        async_uP_RW = 1'b1;
    endtask

    task automatic do_and_check(input string tag, input logic [47:0] pkt, input int delay, input logic [31:0] rd,
                                input logic [31:0] st, input logic [7:0] ec, input logic [7:0] ea,
                                input logic [31:0] ew, input logic [63:0] er);
        logic [63:0] got;
        logic oe_all, ack;
        bit ok;
        int req0;
        req0 = n_req;
        run_txn(pkt, delay, rd, st, got, oe_all, ok, ack);
        check({tag, ".handshakes"}, 64'(ok), 64'd1);
        check({tag, ".reply"}, got, er);
        check({tag, ".cmd"}, 64'(seen_cmd), 64'(ec));
        check({tag, ".addr"}, 64'(seen_addr), 64'(ea));
        check({tag, ".wr_data"}, 64'(seen_wr), 64'(ew));
        check({tag, ".req_pulses"}, 64'(n_req - req0), 64'd1);
        check({tag, ".oe_in_reply"}, 64'(oe_all), 64'd1);
        check({tag, ".ack"}, 64'(ack), 64'd1);
        check({tag, ".oe_after"}, 64'(uP_data_oe), 64'd0);
    endtask

    task automatic poke_h1(input string tag);
        logic seen;
        int req0;
        seen = 1'b0;
        req0 = n_req;
        async_uP_RW = 1'b1;
        async_uP_handshake_1 = 1'b1;
        repeat (6) begin @(negedge clk); seen |= uP_handshake_2; end
        async_uP_handshake_1 = 1'b0;
        repeat (6) begin @(negedge clk); seen |= uP_handshake_2; end
        check({tag, ".hs2_stays_low"}, 64'(seen), 64'd0);
        check({tag, ".no_req"}, 64'(n_req - req0), 64'd0);
    endtask

    initial begin
        logic [47:0] pkt;
        logic [63:0] got;
        logic [31:0] rd, st;
        logic oe_all, ack, oe;
        logic [7:0] b;
        bit ok, k;
        int delay, req0, n, acks, errs;

        tbl[0] = '{48'h1234_5678_1001, 2,   32'h1234_5678, 32'h0000_0000, 8'h01, 8'h10, 32'h1234_5678, 64'h0000_0000_1234_5678};
        tbl[1] = '{48'h0000_0000_0500, 3,   32'h0000_03E8, 32'h0000_0001, 8'h00, 8'h05, 32'h0000_0000, 64'h0000_0001_0000_03E8};
        tbl[2] = '{48'h0000_0000_2200, -1,  32'hDEAD_BEEF, 32'h0000_0000, 8'h00, 8'h22, 32'h0000_0000, 64'hFFFF_FFFF_0000_0000};
        tbl[3] = '{48'hDEAD_BEEF_FF01, 0,   32'hA5A5_5A5A, 32'h8000_0000, 8'h01, 8'hFF, 32'hDEAD_BEEF, 64'h8000_0000_A5A5_5A5A};
        tbl[4] = '{48'h0403_0201_8000, 250, 32'h0000_00FF, 32'h0000_0002, 8'h00, 8'h80, 32'h0403_0201, 64'h0000_0002_0000_00FF};

        repeat (3) @(negedge clk);
        check("reset.hs2", 64'(uP_handshake_2), 64'd0);
        check("reset.ack", 64'(uP_ack), 64'd0);
        check("reset.oe", 64'(uP_data_oe), 64'd0);
        check("reset.req", 64'(reg_req), 64'd0);
        check("reset.outs", {uP_data_out, reg_cmd, reg_address, reg_wr_data}, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        poke_h1("idle");

        for (int i = 0; i < 5; i++)
            do_and_check($sformatf("table%0d", i), tbl[i].pkt, tbl[i].delay, tbl[i].rd, tbl[i].st,
                         tbl[i].exp_cmd, tbl[i].exp_addr, tbl[i].exp_wr, tbl[i].exp_reply);

        poke_h1("after_ack");
        check("after_ack.ack_held", 64'(uP_ack), 64'd1);

        for (int i = 0; i < 20; i++) begin
            pkt   = {16'($urandom), 32'($urandom)};
            delay = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 20));
            rd    = $urandom;
            st    = $urandom;
            do_and_check($sformatf("rand%0d", i), pkt, delay, rd, st, pkt[7:0], pkt[15:8], pkt[47:16],
                         model_reply(delay, rd, st));
        end

        req0 = n_req;
        rsp_delay = 1;
        start_pulse();
        for (int i = 0; i < 3; i++) send_byte(8'hA0 + 8'(i), k);
        run_txn(48'h4433_2211_6601, 1, 32'h0BAD_F00D, 32'h0, got, oe_all, ok, ack);
        check("abort.handshakes", 64'(ok), 64'd1);
        check("abort.req_pulses", 64'(n_req - req0), 64'd1);
        check("abort.pkt", {seen_cmd, seen_addr, seen_wr}, {8'h01, 8'h66, 32'h4433_2211});
        check("abort.reply", got, model_reply(1, 32'h0BAD_F00D, 32'h0));
        check("abort.ack", 64'(ack), 64'd1);

        req0 = n_req;
        rsp_delay = 1; rsp_data = 32'h1111_2222; rsp_status = 32'h0;
        start_pulse();
        for (int i = 0; i < 6; i++) send_byte(8'h30 + 8'(i), k);
        for (int i = 0; i < 4; i++) recv_byte(i == 0 ? 300 : 12, b, oe, k);
        async_uP_RW = 1'b0;
        wait_hs2(1'b1, 12, n);
        check("midreset.byte4_presented", 64'(n != 0), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset.hs2", 64'(uP_handshake_2), 64'd0);
        check("midreset.oe", 64'(uP_data_oe), 64'd0);
        async_uP_handshake_1 = 1'b0;
        async_uP_RW = 1'b1;
        repeat (20) @(negedge clk);
        check("midreset.no_ack", 64'(uP_ack), 64'd0);
        check("midreset.no_new_req", 64'(n_req - req0), 64'd1);
        do_and_check("post_reset", 48'h0000_0000_4200, 2, 32'hCAFE_0001, 32'h0000_0003, 8'h00, 8'h42, 32'h0,
                     model_reply(2, 32'hCAFE_0001, 32'h0000_0003));

        req0 = n_req; acks = 0; errs = 0;
        for (int i = 0; i < 257; i++) begin
            run_txn({32'h0, 8'(i), 8'h00}, 1, 32'(i), 32'h0, got, oe_all, ok, ack);
            if (ack === 1'b1) acks++;
            if (!ok || got !== model_reply(1, 32'(i), 32'h0) || seen_addr !== 8'(i)) errs++;
        end
        check("b2b.acks", 64'(acks), 64'd257);
        check("b2b.req_pulses", 64'(n_req - req0), 64'd257);
        check("b2b.bad_txns", 64'(errs), 64'd0);

        vectors++;
        if (max_lat == 0 || max_lat > 3) begin
            miscompares++;
            $display("FAIL hs2_latency: got %0d cycles, required 1..3", max_lat);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
